// File: rtl/wb_irqc_pkg.sv
// Shared definitions for the wb_irqc interrupt controller: register map,
// FSM state encoding, CURRENT register field positions, byte-lane helper.
package wb_irqc_pkg;

   typedef logic [1:0] reg_off_t;

   // Register offsets (word address bits [1:0])
   localparam reg_off_t REG_PENDING = 2'd0;
   localparam reg_off_t REG_ENABLE  = 2'd1;
   localparam reg_off_t REG_EDGE    = 2'd2;
   localparam reg_off_t REG_CURRENT = 2'd3;

   // Request FSM encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] ACKED = 2'd2;

   // CURRENT register layout
   localparam int CUR_REQ_BIT = 31;
   localparam int CUR_IDX_MSB = 19;
   localparam int CUR_IDX_LSB = 16;
   localparam int CUR_VEC_MSB = 7;
   localparam int CUR_VEC_LSB = 0;

   // Expand the four byte selects into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_irqc_if.sv
// Wishbone slave bus bundle for wb_irqc (classic single-cycle ack).
interface wb_irqc_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [29:0] adr_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_i;
   logic        ack_o;
   logic [31:0] dat_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      input  ack_o, dat_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      output ack_o, dat_o
   );
endinterface

// File: rtl/irqc_prio_enc.sv
// Lowest-index-first priority encoder: valid when any request bit is set,
// idx is the position of the lowest set bit.
module irqc_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [3:0]   idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = 4'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/wb_irqc.sv
// wb_irqc: Wishbone-slave interrupt controller. Latches peripheral interrupt
// lines into PENDING, masks with ENABLE, picks the lowest-index active source
// and holds one request/vector toward the CPU until it is acknowledged or
// withdrawn.
// Build option: define WB_IRQC_SYNC_EN to put a 2-flop synchroniser on every
// irq_i bit (request latency grows from 2 to 4 cycles).
module wb_irqc
   import wb_irqc_pkg::*;
#(
   parameter int         SOURCES  = 8,
   parameter logic [7:0] VEC_BASE = 8'd64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   wb_irqc_if.slave           wb,
   input  logic [SOURCES-1:0] irq_i,
   output logic               irq_req,
   output logic [7:0]         irq_vec,
   input  logic               irq_ack
);

   // Vector for a source index, wrapping modulo 256.
   function automatic logic [7:0] vec_of(input logic [3:0] idx);
      return VEC_BASE + {4'd0, idx};
   endfunction

   logic [SOURCES-1:0] irq_s;
   logic [SOURCES-1:0] irq_prev;
   logic [SOURCES-1:0] rise;
   logic [SOURCES-1:0] pending;
   logic [SOURCES-1:0] enable;
   logic [SOURCES-1:0] edge_cfg;
   logic [SOURCES-1:0] active;
   logic [SOURCES-1:0] wmask;
   logic [SOURCES-1:0] wdat;
   logic [SOURCES-1:0] w1c;
   logic [SOURCES-1:0] ack_clr;
   logic [SOURCES-1:0] win_hot;
   logic [31:0]        lanes;
   logic [31:0]        rd_data;
   logic [1:0]         state;
   logic [3:0]         win_idx;
   logic [3:0]         enc_idx;
   logic               enc_vld;
   logic               win_active;
   logic               bus_req;
   logic               wr_en;
   reg_off_t           reg_sel;
   logic               unused_ok;

`ifdef WB_IRQC_SYNC_EN
   logic [SOURCES-1:0] sync_p0;
   logic [SOURCES-1:0] sync_p1;

   // Two-flop synchroniser ahead of edge detection and level sampling.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= irq_i;
         sync_p1 <= sync_p0;
      end
   end

   assign irq_s = sync_p1;
`else
   assign irq_s = irq_i;
`endif

   assign reg_sel = wb.adr_i[1:0];
   assign bus_req = wb.cyc_i & wb.stb_i & ~wb.ack_o;
   assign wr_en   = bus_req & wb.we_i;
   assign lanes   = lane_mask(wb.sel_i);
   assign wmask   = lanes[SOURCES-1:0];
   assign wdat    = wb.dat_i[SOURCES-1:0];
   assign rise    = irq_s & ~irq_prev;
   assign active  = pending & enable;
   assign irq_req = (state == REQ);

   assign w1c     = (wr_en && reg_sel == REG_PENDING) ? (wdat & wmask) : '0;
   assign ack_clr = (state == REQ && irq_ack) ? (win_hot & edge_cfg) : '0;

   assign unused_ok = ^{wb.adr_i[29:2], wb.dat_i, lanes};

   // One-hot of the latched winner, used for ack-clear and the withdraw test.
   always_comb begin
      win_hot = '0;
      for (int i = 0; i < SOURCES; i++) begin
         win_hot[i] = (win_idx == 4'(i));
      end
   end

   assign win_active = |(active & win_hot);

   irqc_prio_enc #(.N(SOURCES)) u_prio (
      .req   (active),
      .valid (enc_vld),
      .idx   (enc_idx)
   );

   // Pending latch: edge sources set on a rising sample (set beats clear),
   // level sources simply mirror the registered line.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_s;
         pending  <= (edge_cfg & ((pending & ~(w1c | ack_clr)) | rise))
                   | (~edge_cfg & irq_s);
      end
   end

   // ENABLE and EDGE configuration registers with byte-lane write masking.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         enable   <= '0;
         edge_cfg <= '0;
      end else if (wr_en) begin
         if (reg_sel == REG_ENABLE)
            enable <= (enable & ~wmask) | (wdat & wmask);
         if (reg_sel == REG_EDGE)
            edge_cfg <= (edge_cfg & ~wmask) | (wdat & wmask);
      end
   end

   // Read multiplexer; unimplemented high bits read as zero.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_PENDING: rd_data[SOURCES-1:0] = pending;
         REG_ENABLE:  rd_data[SOURCES-1:0] = enable;
         REG_EDGE:    rd_data[SOURCES-1:0] = edge_cfg;
         default: begin
            rd_data[CUR_REQ_BIT]             = irq_req;
            rd_data[CUR_IDX_MSB:CUR_IDX_LSB] = win_idx;
            rd_data[CUR_VEC_MSB:CUR_VEC_LSB] = irq_vec;
         end
      endcase
   end

   // Single-cycle Wishbone ack with read data registered alongside it.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wb.ack_o <= 1'b0;
         wb.dat_o <= '0;
      end else begin
         wb.ack_o <= bus_req;
         wb.dat_o <= (bus_req && !wb.we_i) ? rd_data : '0;
      end
   end

   // Request FSM: latch a winner, hold it without preemption until ack or
   // withdrawal, then one dead cycle after ack before re-arbitrating.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         win_idx <= 4'd0;
         irq_vec <= VEC_BASE;
      end else begin
         case (state)
            IDLE: begin
               if (enc_vld) begin
                  win_idx <= enc_idx;
                  irq_vec <= vec_of(enc_idx);
                  state   <= REQ;
               end
            end
            REQ: begin
               if (irq_ack)
                  state <= ACKED;
               else if (!win_active)
                  state <= IDLE;
            end
            ACKED:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_irqc.sv
// Self-checking bench for wb_irqc: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level reference.
module tb_wb_irqc;

   localparam int         SOURCES  = 8;
   localparam logic [7:0] VEC_BASE = 8'd64;

   logic               clk = 1'b0;
   logic               rst_i;
   logic [SOURCES-1:0] irq_i;
   logic               irq_req;
   logic [7:0]         irq_vec;
   logic               irq_ack;

   wb_irqc_if wb ();

   wb_irqc #(.SOURCES(SOURCES), .VEC_BASE(VEC_BASE)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .wb      (wb),
      .irq_i   (irq_i),
      .irq_req (irq_req),
      .irq_vec (irq_vec),
      .irq_ack (irq_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: what the controller must look like after each edge
   logic [SOURCES-1:0] m_pend = '0;
   logic [SOURCES-1:0] m_en   = '0;
   logic [SOURCES-1:0] m_edge = '0;
   logic [SOURCES-1:0] m_prev = '0;
   bit                 m_req  = 0;   // request presented to CPU
   bit                 m_cool = 0;   // dead cycle right after an ack
   int                 m_src  = 0;
   logic [7:0]         m_vec  = VEC_BASE;
   bit                 m_ack  = 0;
   logic [31:0]        m_dat  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference by one clock edge using the inputs present at it.
   task automatic model_step();
      logic [SOURCES-1:0] np;
      logic [31:0]        lanes;
      logic [31:0]        rd;
      bit                 bus, wr, clr;
      int                 win;
      if (!rst_i) begin
         m_pend = '0; m_en = '0; m_edge = '0; m_prev = '0;
         m_req = 0; m_cool = 0; m_src = 0; m_vec = VEC_BASE;
         m_ack = 0; m_dat = '0;
         return;
      end
      bus = wb.cyc_i && wb.stb_i && !m_ack;
      wr  = bus && wb.we_i;
      for (int b = 0; b < 4; b++) lanes[8*b +: 8] = wb.sel_i[b] ? 8'hFF : 8'h00;
      case (wb.adr_i[1:0])
         2'd0:    rd = 32'(m_pend);
         2'd1:    rd = 32'(m_en);
         2'd2:    rd = 32'(m_edge);
         default: rd = (32'(m_req) << 31) | (32'(m_src) << 16) | 32'(m_vec);
      endcase
      for (int k = 0; k < SOURCES; k++) begin
         if (m_edge[k]) begin
            clr = (wr && wb.adr_i[1:0] == 2'd0 && wb.dat_i[k] && lanes[k])
               || (m_req && irq_ack && m_src == k);
            np[k] = (irq_i[k] && !m_prev[k]) ? 1'b1 : (m_pend[k] && !clr);
         end else begin
            np[k] = irq_i[k];
         end
      end
      if (m_cool) begin
         m_cool = 0;
      end else if (m_req) begin
         if (irq_ack) begin
            m_req = 0; m_cool = 1;
         end else if (!(m_pend[m_src] && m_en[m_src])) begin
            m_req = 0;
         end
      end else begin
         win = -1;
         for (int k = SOURCES - 1; k >= 0; k--)
            if (m_pend[k] && m_en[k]) win = k;
         if (win >= 0) begin
            m_req = 1; m_src = win;
            m_vec = 8'((int'(VEC_BASE) + win) % 256);
         end
      end
      if (wr && wb.adr_i[1:0] == 2'd1)
         m_en = (m_en & ~lanes[SOURCES-1:0]) | (wb.dat_i[SOURCES-1:0] & lanes[SOURCES-1:0]);
      if (wr && wb.adr_i[1:0] == 2'd2)
         m_edge = (m_edge & ~lanes[SOURCES-1:0]) | (wb.dat_i[SOURCES-1:0] & lanes[SOURCES-1:0]);
      m_pend = np;
      m_prev = irq_i;
      m_ack  = bus;
      m_dat  = (bus && !wb.we_i) ? rd : 32'd0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare DUT outputs against the reference on every falling edge.
   always @(negedge clk) begin
      chk("irq_req", 32'(irq_req), 32'(m_req));
      chk("irq_vec", 32'(irq_vec), 32'(m_vec));
      chk("ack_o", 32'(wb.ack_o), 32'(m_ack));
      if (m_ack) chk("dat_o", wb.dat_o, m_dat);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic bus_idle();
      wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 1;
      wb.adr_i = {28'd0, a}; wb.sel_i = 4'hF; wb.dat_i = d;
      step(); bus_idle(); step();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0;
      wb.adr_i = {28'd0, a}; wb.sel_i = 4'hF;
      step(); d = wb.dat_o; bus_idle(); step();
   endtask

   logic [31:0] rv;

   initial begin
      rst_i = 0; irq_i = '0; irq_ack = 0;
      bus_idle(); wb.adr_i = '0; wb.sel_i = '0; wb.dat_i = '0;
      step(); step();
      chk("rst irq_req", 32'(irq_req), 32'd0);
      chk("rst irq_vec", 32'(irq_vec), 32'd64);
      chk("rst ack_o", 32'(wb.ack_o), 32'd0);
      chk("rst dat_o", wb.dat_o, 32'd0);
      rst_i = 1; step();

      // Edge source 0: two-cycle latency, ack retires it
      wr(2'd1, 32'h01); wr(2'd2, 32'h01);
      irq_i = 8'h01; step();
      chk("t1 req early", 32'(irq_req), 32'd0);
      irq_i = 8'h00; step();
      chk("t1 req", 32'(irq_req), 32'd1);
      chk("t1 vec", 32'(irq_vec), 32'd64);
      rd(2'd0, rv); chk("t1 pending", rv, 32'h01);
      rd(2'd3, rv); chk("t1 current", rv, 32'h8000_0040);
      irq_ack = 1; step(); irq_ack = 0;
      chk("t1 req after ack", 32'(irq_req), 32'd0);
      rd(2'd0, rv); chk("t1 pending cleared", rv, 32'h00);

      // Level sources 2 and 3
      wr(2'd2, 32'h00); wr(2'd1, 32'h0C);
      irq_i = 8'h0C; step(); step();
      chk("t2 req", 32'(irq_req), 32'd1);
      chk("t2 vec", 32'(irq_vec), 32'd66);
      irq_ack = 1; step(); irq_ack = 0;
      chk("t2 acked", 32'(irq_req), 32'd0);
      step(); step();
      chk("t2 rereq vec", 32'(irq_vec), 32'd66);
      chk("t2 rereq", 32'(irq_req), 32'd1);
      irq_i = 8'h08; step(); step(); step();
      chk("t2 vec 67", 32'(irq_vec), 32'd67);
      chk("t2 req 67", 32'(irq_req), 32'd1);
      irq_ack = 1; step(); irq_ack = 0;
      wr(2'd1, 32'h00); irq_i = 8'h00; step(); step(); step();

      // No preemption: source 5 held while source 1 arrives
      wr(2'd2, 32'h22); wr(2'd1, 32'h22);
      irq_i = 8'h20; step(); step();
      chk("t3 vec 69", 32'(irq_vec), 32'd69);
      irq_i = 8'h02; step(); step(); step();
      chk("t3 held vec", 32'(irq_vec), 32'd69);
      chk("t3 held req", 32'(irq_req), 32'd1);
      irq_ack = 1; step(); irq_ack = 0; irq_i = 8'h00;
      chk("t3 acked", 32'(irq_req), 32'd0);
      step(); step();
      chk("t3 next vec", 32'(irq_vec), 32'd65);
      chk("t3 next req", 32'(irq_req), 32'd1);
      irq_ack = 1; step(); irq_ack = 0; step(); step();
      wr(2'd1, 32'h00);

      // W1C in the same cycle as a new rising edge: set wins
      wr(2'd2, 32'h10);
      irq_i = 8'h10; step(); irq_i = 8'h00; step();
      rd(2'd0, rv); chk("t4 pending", rv, 32'h10);
      wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 1;
      wb.adr_i = 30'd0; wb.sel_i = 4'hF; wb.dat_i = 32'h10;
      irq_i = 8'h10;
      step(); bus_idle(); irq_i = 8'h00; step();
      rd(2'd0, rv); chk("t4 set wins", rv, 32'h10);
      wr(2'd0, 32'h10);
      rd(2'd0, rv); chk("t4 w1c", rv, 32'h00);

      // Withdraw by disabling source 3
      wr(2'd2, 32'h08); wr(2'd1, 32'h08);
      irq_i = 8'h08; step(); irq_i = 8'h00; step();
      chk("t5 req", 32'(irq_req), 32'd1);
      chk("t5 vec", 32'(irq_vec), 32'd67);
      wr(2'd1, 32'h00);
      chk("t5 withdrawn", 32'(irq_req), 32'd0);
      rd(2'd3, rv); chk("t5 current", rv, 32'h0003_0043);
      wr(2'd0, 32'h08);

      // CURRENT read during REQ on source 6, then reset mid-request
      wr(2'd2, 32'h40); wr(2'd1, 32'h40);
      irq_i = 8'h40; step(); irq_i = 8'h00; step();
      wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0; wb.adr_i = 30'd3; wb.sel_i = 4'hF;
      step();
      chk("t6 ack", 32'(wb.ack_o), 32'd1);
      chk("t6 current", wb.dat_o, 32'h8006_0046);
      step();
      chk("t6 ack one cycle", 32'(wb.ack_o), 32'd0);
      bus_idle(); step();
      rst_i = 0; step();
      chk("t6 rst req", 32'(irq_req), 32'd0);
      chk("t6 rst vec", 32'(irq_vec), 32'd64);
      rst_i = 1; step();
      rd(2'd1, rv); chk("t6 rst enable", rv, 32'h0);
      rd(2'd2, rv); chk("t6 rst edge", rv, 32'h0);
      rd(2'd0, rv); chk("t6 rst pending", rv, 32'h0);

      // Randomized traffic checked by the reference every cycle
      for (int c = 0; c < 4000; c++) begin
         wb.cyc_i = ($urandom_range(0, 3) != 0);
         wb.stb_i = ($urandom_range(0, 2) != 0);
         wb.we_i  = $urandom_range(0, 1);
         wb.adr_i = {28'($urandom), 2'($urandom)};
         wb.sel_i = 4'($urandom);
         wb.dat_i = $urandom;
         for (int k = 0; k < SOURCES; k++)
            if ($urandom_range(0, 7) == 0) irq_i[k] = ~irq_i[k];
         irq_ack = ($urandom_range(0, 3) == 0);
         rst_i   = ($urandom_range(0, 599) != 0);
         step();
      end
      bus_idle(); irq_ack = 0; rst_i = 1; irq_i = '0;
      step(); step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_irqc.md
Name: wb_irqc

Overview:
- Wishbone-slave interrupt controller; the stage directly upstream of the CPU bus interface's interrupt inputs (irq_req / irq_vec / irq_ack).
- Collects peripheral interrupt lines (UART, timer, SPI/Ethernet, PS2) and latches them into pending bits.
- Masks and prioritises them, then presents one request with an 8-bit vector.
- Retires the request on the CPU's interrupt-acknowledge pulse.

Parameters:
- SOURCES, 8, number of interrupt inputs (1..16).
- VEC_BASE, 8'd64, vector for source 0; source k gets VEC_BASE+k, modulo 256.

Ports:
- clk_i     in   1   system clock.
- rst_i     in   1   reset, synchronous, active-low.
- cyc_i     in   1   Wishbone cycle.
- stb_i     in   1   Wishbone strobe (decoded select for this block).
- we_i      in   1   write enable.
- adr_i     in   30  word address; only adr_i[1:0] decoded.
- sel_i     in   4   byte selects.
- dat_i     in   32  write data.
- ack_o     out  1   Wishbone ack.
- dat_o     out  32  read data.
- irq_i     in   SOURCES  peripheral interrupt lines, active-high.
- irq_req   out  1   interrupt request to CPU interface.
- irq_vec   out  8   vector for the current request.
- irq_ack   in   1   one-cycle pulse when the CPU acknowledges the vector.

Behaviour:
- Reset (rst_i low at clk edge): PENDING, ENABLE, EDGE = 0; state IDLE; irq_req=0; irq_vec=VEC_BASE; ack_o=0; dat_o=0.
- Registers (adr_i[1:0]); bits above SOURCES read 0, writes to them are ignored; byte lanes honour sel_i.
  - 0 PENDING: read; write-1-to-clear, edge sources only.
  - 1 ENABLE: read/write.
  - 2 EDGE: read/write; 1=rising-edge source, 0=level source.
  - 3 CURRENT: read-only; bit31=irq_req, [7:0]=irq_vec, [19:16]=latched source index.
- Wishbone timing:
  - ack_o pulses exactly one cycle, in the cycle after cyc_i&stb_i&!ack_o.
  - dat_o is valid with ack_o.
  - The write takes effect at the ack edge.
  - No ack while cyc_i or stb_i is low.
- Pending update, per cycle:
  - Edge source: set on irq_i 0->1 (previous sample registered).
  - Level source: PENDING bit = irq_i, registered; W1C has no effect.
  - Same cycle set and clear (W1C or ack-clear) on an edge source: set wins.
- Active set = PENDING & ENABLE. Priority: lowest index wins.
- Latency: irq_i rising at edge n -> PENDING at n+1 -> irq_req/irq_vec at n+2.
- FSM:
  - IDLE: if active set is non-zero, latch winner index and vector, assert irq_req, go to REQ.
  - REQ: irq_vec held stable, with no preemption by a higher-priority source.
    - irq_ack=1: clear the winner's PENDING if it is an edge source; drop irq_req; go to ACKED.
    - Else, if the winner is no longer in the active set (disabled, level dropped, or W1C): drop irq_req; go to IDLE (withdraw).
  - ACKED: irq_req=0 for this one cycle; go to IDLE. A new request re-evaluates from the next cycle.
- irq_ack while IDLE or ACKED: ignored.
- Reset mid-REQ: irq_req drops at that edge; all state is cleared.

Optional Feature:
- Macro: WB_IRQC_SYNC_EN.
- Defined: each irq_i bit passes a 2-flop synchroniser before edge detection and level sampling. Latency becomes 4 cycles (irq_i rise to irq_req).
- Undefined: irq_i is sampled directly; latency is 2 cycles.

Decomposition:
- Package wb_irqc_pkg holds:
  - register offsets REG_PENDING=0, REG_ENABLE=1, REG_EDGE=2, REG_CURRENT=3;
  - FSM state encoding IDLE/REQ/ACKED;
  - CURRENT field bit positions.
- One sub-module: irqc_prio_enc, a combinational lowest-index-first encoder producing a valid flag and a 4-bit index.

Test Plan:
- ENABLE=0x01, EDGE=0x01; pulse irq_i[0] at edge n -> PENDING=0x01 at n+1; irq_req=1, irq_vec=64 at n+2. irq_ack pulse -> irq_req=0 next cycle; PENDING=0.
- ENABLE=0x0C, EDGE=0; hold irq_i[2] and irq_i[3] high -> irq_vec=66. Ack; irq_i[2] still high -> re-request, vec 66. Drop irq_i[2] -> vec 67.
- In REQ with source 5 (vec 69); raise enabled source 1 -> irq_vec stays 69 until ack; next request is vec 65.
- Edge source 4 pending; W1C write 0x10 in the same cycle as a new rising edge -> PENDING bit 4 remains 1.
- In REQ on source 3; write ENABLE=0 -> irq_req falls the next cycle; state returns to IDLE; CURRENT bit31=0.
- Read adr 3 during REQ on source 6 -> dat_o=0x8006_0046; ack_o high for exactly 1 cycle. Assert rst_i low mid-REQ -> irq_req=0 and all registers 0.
